// File: rtl/aes_in_packer.sv
// AES controller input stage: packs a 32-bit bus word stream into 129-bit
// {last, data} entries (one command word, then 128-bit blocks) and queues them in a show-ahead FIFO.
module aes_in_packer #(
   parameter int BUS_DATA_WIDTH  = 32,
   parameter int FIFO_DEPTH      = 256,
   parameter int FIFO_ADDR_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_data_wren,
   input  logic                      bus_tlast,
   input  logic [BUS_DATA_WIDTH-1:0] bus_data,
   output logic                      controller_in_busy,
   output logic                      fifo_rd_tvalid,
   input  logic                      fifo_rd_tready,
   output logic [128:0]              fifo_rdata,
   output logic                      fifo_empty,
   output logic                      overflow
);

   localparam int ENTRY_W = 129;
   localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ZERO = {(FIFO_ADDR_WIDTH+1){1'b0}};
   localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ONE  = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [FIFO_ADDR_WIDTH:0]   BUSY_TH  = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH - 32'd1);

   if (BUS_DATA_WIDTH != 32'd32) begin : g_bad_bus_width
      $error("aes_in_packer: BUS_DATA_WIDTH must be 32");
   end
   if ((FIFO_DEPTH < 32'd4) || ((FIFO_DEPTH & (FIFO_DEPTH - 32'd1)) != 32'd0) ||
       (FIFO_DEPTH != (32'd1 << FIFO_ADDR_WIDTH))) begin : g_bad_depth
      $error("aes_in_packer: FIFO_DEPTH must be a power of two >= 4 equal to 2**FIFO_ADDR_WIDTH");
   end

   typedef enum logic [0:0] {ST_CMD = 1'b0, ST_BLK = 1'b1} state_t;

   state_t                     state_r, state_nxt_s;
   logic [1:0]                 word_cnt_r, word_cnt_nxt_s;
   logic [127:0]               asm_r, asm_nxt_s, blk_s;
   logic                       accept_s, drop_s, push_s, pop_s;
   logic [ENTRY_W-1:0]         push_data_s;
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
   logic [FIFO_ADDR_WIDTH:0]   count_r, count_nxt_s;
   logic                       busy_r, overflow_r;
   logic [ENTRY_W-1:0]         mem_r [FIFO_DEPTH];

   assign accept_s = bus_data_wren && !busy_r;
   assign drop_s   = bus_data_wren && busy_r;
   assign pop_s    = fifo_rd_tvalid && fifo_rd_tready;

   // Assembly register with the current word merged in; first word lands in the MSBs.
   always_comb begin
      blk_s = asm_r;
      case (word_cnt_r)
         2'd0:    blk_s[127:96] = bus_data;
         2'd1:    blk_s[95:64]  = bus_data;
         2'd2:    blk_s[63:32]  = bus_data;
         2'd3:    blk_s[31:0]   = bus_data;
         default: blk_s = asm_r;
      endcase
   end

   // FSM state register together with word counter and assembly register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_CMD;
         word_cnt_r <= 2'd0;
         asm_r      <= 128'd0;
      end else begin
         state_r    <= state_nxt_s;
         word_cnt_r <= word_cnt_nxt_s;
         asm_r      <= asm_nxt_s;
      end
   end

   // Next-state logic; the assembly register is cleared on every block push so unsent words read as zero.
   always_comb begin
      state_nxt_s    = state_r;
      word_cnt_nxt_s = word_cnt_r;
      asm_nxt_s      = asm_r;
      if (accept_s) begin
         case (state_r)
            ST_CMD: begin
               if (bus_tlast) begin
                  state_nxt_s = ST_CMD;
               end else begin
                  state_nxt_s = ST_BLK;
               end
            end
            ST_BLK: begin
               if (bus_tlast || (word_cnt_r == 2'd3)) begin
                  state_nxt_s    = bus_tlast ? ST_CMD : ST_BLK;
                  word_cnt_nxt_s = 2'd0;
                  asm_nxt_s      = 128'd0;
               end else begin
                  word_cnt_nxt_s = word_cnt_r + 2'd1;
                  asm_nxt_s      = blk_s;
               end
            end
            default: begin
               state_nxt_s    = ST_CMD;
               word_cnt_nxt_s = 2'd0;
               asm_nxt_s      = 128'd0;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // FSM outputs: FIFO push strobe and entry contents.
   always_comb begin
      push_s      = 1'b0;
      push_data_s = {ENTRY_W{1'b0}};
      if (accept_s) begin
         case (state_r)
            ST_CMD: begin
               push_s      = 1'b1;
               push_data_s = {bus_tlast, 96'd0, bus_data};
            end
            ST_BLK: begin
               if (bus_tlast || (word_cnt_r == 2'd3)) begin
                  push_s      = 1'b1;
                  push_data_s = {bus_tlast, blk_s};
               end else begin
                  push_s = 1'b0;
               end
            end
            default: push_s = 1'b0;
         endcase
      end else begin
         push_s = 1'b0;
      end
   end

   // Occupancy for the coming cycle.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // FIFO pointers, occupancy, back-pressure and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r   <= {FIFO_ADDR_WIDTH{1'b0}};
         rd_ptr_r   <= {FIFO_ADDR_WIDTH{1'b0}};
         count_r    <= CNT_ZERO;
         busy_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         count_r    <= count_nxt_s;
         busy_r     <= (count_nxt_s >= BUSY_TH);
         overflow_r <= overflow_r | drop_s;
      end
   end

   // Entry storage, not reset.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= push_data_s;
   end

   assign fifo_rdata         = mem_r[rd_ptr_r];
   assign fifo_empty         = (count_r == CNT_ZERO);
   assign fifo_rd_tvalid     = !fifo_empty;
   assign controller_in_busy = busy_r;
   assign overflow           = overflow_r;

endmodule
